// File: rtl/dm_master.sv
// ============================================================================
// Module   : dm_master
// Brief    : Initiator-side load/store sequencer between the MEM stage and a
//            word-wide data memory (combinational read, synchronous write).
//            Handles byte/half/word access with sub-word read-modify-write,
//            lane extraction with sign/zero extension and error detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_master #(
  parameter int DM_AW = 12
) (
  input  logic        clk,
  input  logic        reset,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // memory side
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_scr,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_dout
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // request latches, valid from the accept edge until the next accept
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;

  // word read from memory, feeds the store merge
  logic [31:0] r_rdbuf;

  // registered response payload
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_misalign;
  logic        w_out_of_range;
  logic        w_req_err;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Classify the incoming request; an error skips memory access entirely.
  always_comb begin
    w_misalign = 1'b0;
    unique case (req_size)
      c_SIZE_BYTE: w_misalign = 1'b0;
      c_SIZE_HALF: w_misalign = req_addr[0];
      c_SIZE_WORD: w_misalign = (req_addr[1:0] != 2'b00);
      c_SIZE_ILL:  w_misalign = 1'b1;
    endcase
    w_out_of_range = ((req_addr >> DM_AW) != 32'd0);
    w_req_err      = w_misalign || w_out_of_range;
  end

  // Extract the addressed lane from the memory word and extend it.
  always_comb begin
    w_ld_byte = 8'd0;
    unique case (r_addr[1:0])
      2'd0: w_ld_byte = dm_dout[7:0];
      2'd1: w_ld_byte = dm_dout[15:8];
      2'd2: w_ld_byte = dm_dout[23:16];
      2'd3: w_ld_byte = dm_dout[31:24];
    endcase
    w_ld_half = r_addr[1] ? dm_dout[31:16] : dm_dout[15:0];
    unique case (r_size)
      c_SIZE_BYTE: w_load_data = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
      c_SIZE_HALF: w_load_data = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
      default:     w_load_data = dm_dout;
    endcase
  end

  // Merge store data into the buffered word (little-endian lanes).
  always_comb begin
    w_merged = r_rdbuf;
    unique case (r_size)
      c_SIZE_BYTE: begin
        unique case (r_addr[1:0])
          2'd0: w_merged[7:0]   = r_wdata[7:0];
          2'd1: w_merged[15:8]  = r_wdata[7:0];
          2'd2: w_merged[23:16] = r_wdata[7:0];
          2'd3: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      c_SIZE_HALF: begin
        if (r_addr[1]) begin
          w_merged[31:16] = r_wdata[15:0];
        end else begin
          w_merged[15:0] = r_wdata[15:0];
        end
      end
      default: w_merged = r_wdata;
    endcase
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt = S_RSP;
          end else if (!req_we) begin
            w_state_nxt = S_RD;
          end else if (req_size == c_SIZE_WORD) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD:  w_state_nxt = r_we ? S_WR : S_RSP;
      S_WR:  w_state_nxt = S_RSP;
      S_RSP: w_state_nxt = rsp_ready ? S_IDLE : S_RSP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latches, read buffer and response payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= 32'd0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= 32'd0;
      r_pc     <= 32'd0;
      r_rdbuf  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= req_addr;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_we     <= req_we;
        r_wdata  <= req_wdata;
        r_pc     <= req_pc;
        r_rdata  <= 32'd0;
        r_err    <= w_req_err;
      end
      if (r_state == S_RD) begin
        r_rdbuf <= dm_dout;
        if (!r_we) begin
          r_rdata <= w_load_data;
        end
      end
    end
  end

  // Strobe is decoded straight from state so an asynchronous reset drops it
  // at once and an interrupted store never reaches memory.
  assign dm_scr    = (r_state == S_WR);
  assign dm_din    = dm_scr ? w_merged : 32'd0;
  assign dm_addr   = {r_addr[31:2], 2'b00};
  assign dm_pc     = r_pc;
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

`default_nettype wire
